stereo_band_buffer: RTL and testbench

Upstream feeder for the per-pixel disparity search unit. It accepts a raster stream of paired left/right pixels and stores them in a ring of WIN+1 row slots per image. Whenever WIN consecutive rows are resident, it presents them as a flattened band. It then sweeps the column index across the band, issuing one search per column and waiting for the search unit to report completion before moving on.

---
 rtl/stereo_band_buffer.sv | 158 +++++++++++++++
 tb/tb_stereo_band_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_band_buffer.sv
// Stereo row buffer: stores a ring of WIN+1 rows per image and sweeps the
// column index across each WIN-row band, one search request per column.
module stereo_band_buffer #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 48,
  parameter int IMG_W_ARR = 6,
  parameter int ROW_BITS  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [DATA_SIZE-1:0]           pix_L,
  input  logic [DATA_SIZE-1:0]           pix_R,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] band_L,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] band_R,
  output logic                           band_valid,
  output logic [ROW_BITS-1:0]            band_row,
  output logic [IMG_W_ARR-1:0]           col_index,
  output logic                           col_start,
  input  logic                           disp_done,
  output logic                           frame_done
);

  localparam int SLOTS     = WIN + 1;
  localparam int SLOT_BITS = $clog2(SLOTS);
  localparam int HELD_BITS = $clog2(SLOTS + 1);
  localparam logic [IMG_W_ARR-1:0] LAST_COL  = IMG_W_ARR'(IMG_W - WIN);
  localparam logic [IMG_W_ARR-1:0] WR_LAST   = IMG_W_ARR'(IMG_W - 1);
  localparam logic [ROW_BITS-1:0]  LAST_BAND = ROW_BITS'(IMG_H - WIN);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_ADVANCE} state_t;

  state_t                 state_q, state_d;
  logic [SLOT_BITS-1:0]   wr_slot_q, wr_slot_d;
  logic [SLOT_BITS-1:0]   top_slot_q, top_slot_d;
  logic [IMG_W_ARR-1:0]   wr_col_q, wr_col_d;
  logic [IMG_W_ARR-1:0]   col_q, col_d;
  logic [HELD_BITS-1:0]   rows_held_q, rows_held_d;
  logic [HELD_BITS-1:0]   held_dec;
  logic [ROW_BITS-1:0]    band_row_q, band_row_d;
  logic                   accept;
  logic                   row_done;

  logic [DATA_SIZE-1:0] mem_l [SLOTS][IMG_W];
  logic [DATA_SIZE-1:0] mem_r [SLOTS][IMG_W];

  function automatic logic [SLOT_BITS-1:0] slot_add(input logic [SLOT_BITS-1:0] s,
                                                    input int n);
    int t;
    t = (int'(s) + n) % SLOTS;
    return SLOT_BITS'(t);
  endfunction

  assign pix_ready = (rows_held_q < HELD_BITS'(SLOTS));
  assign accept    = pix_valid && pix_ready;
  assign row_done  = accept && (wr_col_q == WR_LAST);

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_l[wr_slot_q][wr_col_q] <= pix_L;
      mem_r[wr_slot_q][wr_col_q] <= pix_R;
    end
  end

  always_comb begin
    wr_col_d  = wr_col_q;
    wr_slot_d = wr_slot_q;
    if (accept) begin
      if (wr_col_q == WR_LAST) begin
        wr_col_d  = '0;
        wr_slot_d = slot_add(wr_slot_q, 1);
      end else begin
        wr_col_d = wr_col_q + IMG_W_ARR'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    top_slot_d = top_slot_q;
    band_row_d = band_row_q;
    held_dec   = '0;
    case (state_q)
      S_FILL: begin
        if (rows_held_q >= HELD_BITS'(WIN)) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (disp_done) begin
          if (col_q < LAST_COL) begin
            col_d   = col_q + IMG_W_ARR'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        col_d   = '0;
        state_d = S_FILL;
        // The last band of a frame releases all its rows at once.
        if (band_row_q == LAST_BAND) begin
          top_slot_d = slot_add(top_slot_q, WIN);
          held_dec   = HELD_BITS'(WIN);
          band_row_d = '0;
        end else begin
          top_slot_d = slot_add(top_slot_q, 1);
          held_dec   = HELD_BITS'(1);
          band_row_d = band_row_q + ROW_BITS'(1);
        end
      end
      default: state_d = S_FILL;
    endcase
    rows_held_d = rows_held_q + HELD_BITS'(row_done) - held_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_slot_q   <= '0;
      top_slot_q  <= '0;
      wr_col_q    <= '0;
      col_q       <= '0;
      rows_held_q <= '0;
      band_row_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_slot_q   <= wr_slot_d;
      top_slot_q  <= top_slot_d;
      wr_col_q    <= wr_col_d;
      col_q       <= col_d;
      rows_held_q <= rows_held_d;
      band_row_q  <= band_row_d;
    end
  end

  assign band_valid = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign col_start  = (state_q == S_ISSUE);
  assign frame_done = (state_q == S_ADVANCE) && (band_row_q == LAST_BAND);
  assign col_index  = col_q;
  assign band_row   = band_row_q;

  // Band row r=0 is the oldest resident row, at top_slot.
  for (genvar r = 0; r < WIN; r++) begin : g_row
    logic [SLOT_BITS-1:0] slot;
    assign slot = slot_add(top_slot_q, r);
    for (genvar c = 0; c < IMG_W; c++) begin : g_col
      assign band_L[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = mem_l[slot][c];
      assign band_R[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = mem_r[slot][c];
    end
  end

endmodule

// File: tb/tb_stereo_band_buffer.sv
// Directed bench for stereo_band_buffer: fill, column sweep, stall, ignored
// done pulses, full frame and mid-search reset.
module tb_stereo_band_buffer;
  localparam int WIN = 15, DS = 8, IW = 64, IH = 48, IWA = 6, RB = 6;
  localparam int BW = DS * IW * WIN;

  logic          clk = 1'b0;
  logic          rst, pix_valid, pix_ready, disp_done;
  logic          band_valid, col_start, frame_done;
  logic [DS-1:0] pix_L, pix_R;
  logic [BW-1:0] band_L, band_R;
  logic [RB-1:0] band_row;
  logic [IWA-1:0] col_index;

  int errors = 0, checks = 0;
  int src_idx, src_limit, n_starts, n_frames, starts_at_frame;
  int start_cnt[IW];
  bit auto_done, done_pend, prev_done, frame_after_done;

  always #5 clk = ~clk;

  stereo_band_buffer #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IW), .IMG_H(IH),
                       .IMG_W_ARR(IWA), .ROW_BITS(RB)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_L(pix_L), .pix_R(pix_R), .band_L(band_L), .band_R(band_R),
    .band_valid(band_valid), .band_row(band_row), .col_index(col_index),
    .col_start(col_start), .disp_done(disp_done), .frame_done(frame_done));

  function automatic logic [7:0] pl(int f, int r, int c);
    return 8'(f * 91 + r * 37 + c * 5 + 3);
  endfunction

  function automatic logic [7:0] pr(int f, int r, int c);
    return 8'(f * 53 + r * 11 + c * 29 + 200);
  endfunction

  function automatic int band_errs(int f, int r0);
    int n = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) begin
        int b = DS * (r * IW + c);
        if (band_L[b +: DS] !== pl(f, r0 + r, c)) n++;
        if (band_R[b +: DS] !== pr(f, r0 + r, c)) n++;
      end
    return n;
  endfunction

  task automatic drive_pix();
    if (src_idx < src_limit) begin
      int f = src_idx / (IW * IH);
      int r = (src_idx / IW) % IH;
      int c = src_idx % IW;
      pix_valid = 1'b1;
      pix_L = pl(f, r, c);
      pix_R = pr(f, r, c);
    end else begin
      pix_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    bit acc;
    acc = pix_valid && pix_ready;
    @(posedge clk); #1;
    if (acc) src_idx++;
    prev_done = disp_done;
    if (frame_done) begin
      n_frames++;
      if (n_frames == 1) begin
        starts_at_frame  = n_starts;
        frame_after_done = prev_done;
      end
    end
    disp_done = auto_done && done_pend;
    if (disp_done) done_pend = 1'b0;
    if (col_start) begin
      n_starts++;
      start_cnt[col_index]++;
      done_pend = 1'b1;
    end
    drive_pix();
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; disp_done = 1'b0; pix_L = '0; pix_R = '0;
    auto_done = 1'b0; done_pend = 1'b0; src_idx = 0; src_limit = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
    checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL reset_band_valid: got %b want 0", band_valid); end
    checks++; if (col_start !== 1'b0) begin errors++; $display("FAIL reset_col_start: got %b want 0", col_start); end
    checks++; if (col_index !== 6'd0) begin errors++; $display("FAIL reset_col_index: got %0d want 0", col_index); end
    checks++; if (band_row !== 6'd0) begin errors++; $display("FAIL reset_band_row: got %0d want 0", band_row); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_band_fill();
    int cyc = 0;
    bit dropped = 1'b0;
    n_starts = 0; n_frames = 0; src_idx = 0; src_limit = WIN * IW;
    auto_done = 1'b0; done_pend = 1'b0;
    for (int i = 0; i < IW; i++) start_cnt[i] = 0;
    drive_pix();
    disp_done = 1'b1;  // done pulses while filling must be ignored
    while (src_idx < src_limit && cyc < 2000) begin
      if (!pix_ready) dropped = 1'b1;
      cycle();
      cyc++;
      if (cyc < 8) disp_done = 1'b1;
    end
    disp_done = 1'b0;
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL fill_ready_held: got drop=%b want 0", dropped); end
    checks++; if (cyc !== WIN * IW) begin errors++; $display("FAIL fill_cycles: got %0d want %0d", cyc, WIN * IW); end
    checks++; if (n_starts !== 0 || col_start !== 1'b0 || band_valid !== 1'b0) begin errors++; $display("FAIL fill_early_start: got starts=%0d cs=%b bv=%b want 0 0 0", n_starts, col_start, band_valid); end
    cycle();
    checks++; if (col_start !== 1'b1) begin errors++; $display("FAIL fill_first_start: got %b want 1", col_start); end
    checks++; if (col_index !== 6'd0 || band_row !== 6'd0) begin errors++; $display("FAIL fill_first_idx: got col=%0d row=%0d want 0 0", col_index, band_row); end
    checks++; if (band_valid !== 1'b1) begin errors++; $display("FAIL fill_band_valid: got %b want 1", band_valid); end
    checks++; if (band_errs(0, 0) !== 0) begin errors++; $display("FAIL fill_band_data: got %0d bad pixels want 0", band_errs(0, 0)); end
  endtask

  task automatic test_columns();
    int cyc = 0;
    int bad = 0;
    auto_done = 1'b1;
    while (band_valid && cyc < 1000) begin cycle(); cyc++; end
    checks++; if (band_valid !== 1'b0) begin errors++; $display("FAIL cols_timeout: got band_valid=%b want 0", band_valid); end
    checks++; if (n_starts !== IW - WIN + 1) begin errors++; $display("FAIL cols_count: got %0d want %0d", n_starts, IW - WIN + 1); end
    for (int i = 0; i < IW; i++)
      if (start_cnt[i] !== ((i <= IW - WIN) ? 1 : 0)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL cols_each_once: got %0d bad columns want 0", bad); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL cols_frame_done: got %b want 0", frame_done); end
    cycle();
    checks++; if (band_row !== 6'd1 || band_valid !== 1'b0 || col_index !== 6'd0) begin errors++; $display("FAIL cols_advance: got row=%0d bv=%b col=%0d want 1 0 0", band_row, band_valid, col_index); end
    repeat (3) cycle();
    checks++; if (n_starts !== IW - WIN + 1 || band_valid !== 1'b0) begin errors++; $display("FAIL cols_no_row_wait: got starts=%0d bv=%b want %0d 0", n_starts, band_valid, IW - WIN + 1); end
  endtask

  task automatic test_stall();
    int cyc = 0;
    bit snapped = 1'b0, changed = 1'b0;
    logic [BW-1:0] snap_l, snap_r;
    auto_done = 1'b0; src_limit = 18 * IW;
    drive_pix();
    while (pix_ready && cyc < 400) begin
      cycle(); cyc++;
      if (band_valid && !snapped) begin snap_l = band_L; snap_r = band_R; snapped = 1'b1; end
      else if (snapped && (band_L !== snap_l || band_R !== snap_r)) changed = 1'b1;
    end
    checks++; if (src_idx !== 17 * IW) begin errors++; $display("FAIL stall_accepted: got %0d want %0d", src_idx, 17 * IW); end
    repeat (20) begin
      cycle();
      if (band_L !== snap_l || band_R !== snap_r) changed = 1'b1;
    end
    checks++; if (pix_ready !== 1'b0 || src_idx !== 17 * IW) begin errors++; $display("FAIL stall_hold: got ready=%b idx=%0d want 0 %0d", pix_ready, src_idx, 17 * IW); end
    checks++; if (snapped !== 1'b1 || changed !== 1'b0) begin errors++; $display("FAIL stall_band_stable: got snapped=%b changed=%b want 1 0", snapped, changed); end
    checks++; if (band_valid !== 1'b1 || band_row !== 6'd1 || col_index !== 6'd0) begin errors++; $display("FAIL stall_state: got bv=%b row=%0d col=%0d want 1 1 0", band_valid, band_row, col_index); end
    checks++; if (band_errs(0, 1) !== 0) begin errors++; $display("FAIL stall_band_data: got %0d bad pixels want 0", band_errs(0, 1)); end
  endtask

  task automatic test_ignored_done();
    int s0 = n_starts;
    disp_done = 1'b1;
    cycle();
    checks++; if (col_start !== 1'b1 || col_index !== 6'd1) begin errors++; $display("FAIL ign_step: got cs=%b col=%0d want 1 1", col_start, col_index); end
    disp_done = 1'b1;  // sampled in ISSUE
    cycle();
    repeat (5) cycle();
    checks++; if (col_index !== 6'd1 || band_valid !== 1'b1 || col_start !== 1'b0) begin errors++; $display("FAIL ign_issue_done: got col=%0d bv=%b cs=%b want 1 1 0", col_index, band_valid, col_start); end
    checks++; if (n_starts !== s0 + 1) begin errors++; $display("FAIL ign_extra_start: got %0d want %0d", n_starts, s0 + 1); end
  endtask

  task automatic test_frame();
    int cyc = 0;
    pix_valid = 1'b0; disp_done = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    src_idx = 0; src_limit = IW * (IH + WIN + 3);
    n_starts = 0; n_frames = 0; done_pend = 1'b0; auto_done = 1'b1;
    drive_pix();
    while (n_frames < 1 && cyc < 30000) begin cycle(); cyc++; end
    checks++; if (n_frames !== 1) begin errors++; $display("FAIL frame_timeout: got frames=%0d want 1", n_frames); end
    checks++; if (starts_at_frame !== 34 * 50) begin errors++; $display("FAIL frame_starts: got %0d want %0d", starts_at_frame, 34 * 50); end
    checks++; if (frame_after_done !== 1'b1) begin errors++; $display("FAIL frame_after_done: got %b want 1", frame_after_done); end
    cyc = 0;
    while (!col_start && cyc < 3000) begin cycle(); cyc++; end
    checks++; if (col_start !== 1'b1 || band_row !== 6'd0 || col_index !== 6'd0) begin errors++; $display("FAIL frame_next_band: got cs=%b row=%0d col=%0d want 1 0 0", col_start, band_row, col_index); end
    checks++; if (band_errs(1, 0) !== 0) begin errors++; $display("FAIL frame_next_data: got %0d bad pixels want 0", band_errs(1, 0)); end
    checks++; if (n_frames !== 1) begin errors++; $display("FAIL frame_once: got %0d want 1", n_frames); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    while (!(col_start && col_index == 6'd20 && band_row == 6'd2) && cyc < 2000) begin cycle(); cyc++; end
    auto_done = 1'b0;
    cycle();
    checks++; if (band_valid !== 1'b1 || col_index !== 6'd20 || band_row !== 6'd2) begin errors++; $display("FAIL mid_pre: got bv=%b col=%0d row=%0d want 1 20 2", band_valid, col_index, band_row); end
    #2;
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (band_valid !== 1'b0 || col_start !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_flags: got bv=%b cs=%b fd=%b want 0 0 0", band_valid, col_start, frame_done); end
    checks++; if (col_index !== 6'd0 || band_row !== 6'd0 || pix_ready !== 1'b1) begin errors++; $display("FAIL mid_counters: got col=%0d row=%0d ready=%b want 0 0 1", col_index, band_row, pix_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    test_band_fill();
  endtask

  initial begin
    test_reset();
    test_band_fill();
    test_columns();
    test_stall();
    test_ignored_done();
    test_frame();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
